// File: rtl/flt_regctrl.sv
// flt_regctrl: register-bus responder and run controller for the filter block.
// Decodes the FLTCTRL..FLTCOLOR window, holds the programming registers, launches
// the filter core and tracks busy/done with a level interrupt.
// Optional feature macro: FLT_TIMEOUT_EN adds a RUN watchdog and FLTSTAT bit1 sticky.
module flt_regctrl #(
    parameter logic [15:0] BASE_ADDR      = 16'h4000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFF_FFFF
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [15:0] WRADDR,
    input  logic [3:0]  BYTEEN,
    input  logic        WREN,
    input  logic [31:0] WDATA,
    input  logic [15:0] RDADDR,
    input  logic        RDEN,
    output logic [31:0] RDATA,
    output logic        FLT_IRQ,
    output logic        core_start,
    output logic [31:0] core_src,
    output logic [31:0] core_frm,
    output logic [2:0]  core_color,
    input  logic        core_done
);

    localparam logic [15:0] ADDR_CTRL  = BASE_ADDR + 16'h0000;
    localparam logic [15:0] ADDR_STAT  = BASE_ADDR + 16'h0004;
    localparam logic [15:0] ADDR_INT   = BASE_ADDR + 16'h0008;
    localparam logic [15:0] ADDR_SRC   = BASE_ADDR + 16'h000c;
    localparam logic [15:0] ADDR_FRM   = BASE_ADDR + 16'h0010;
    localparam logic [15:0] ADDR_COLOR = BASE_ADDR + 16'h0014;

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;
    logic [31:0] src_q, src_d;
    logic [31:0] frm_q, frm_d;
    logic [2:0]  color_q, color_d;
    logic [31:0] rd_val;
    logic        start;
    logic        finish;
    logic        timeout_hit;

    logic wr_ctrl, wr_int, wr_src, wr_frm, wr_color;
    assign wr_ctrl  = WREN && (WRADDR == ADDR_CTRL);
    assign wr_int   = WREN && (WRADDR == ADDR_INT);
    assign wr_src   = WREN && (WRADDR == ADDR_SRC);
    assign wr_frm   = WREN && (WRADDR == ADDR_FRM);
    assign wr_color = WREN && (WRADDR == ADDR_COLOR);

`ifdef FLT_TIMEOUT_EN
    logic [23:0] cnt_q, cnt_d;

    // Watchdog counter: cleared on launch, counts each RUN cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // A real completion in the same cycle takes precedence over the watchdog.
    assign timeout_hit = (state_q == StRun) && !core_done && (cnt_q + 24'd1 == TIMEOUT_CYCLES);

    // Watchdog counter register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // FSM next state; a start is only honoured while idle.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            StIdle: begin
                if (wr_ctrl && BYTEEN[0] && WDATA[0]) begin
                    start   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (core_done || timeout_hit) begin
                    finish  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Programming register updates; the done-flag set is applied after W1C so set wins.
    always_comb begin
        irq_en_d = irq_en_q;
        done_d   = done_q;
        tmo_d    = tmo_q;
        src_d    = src_q;
        frm_d    = frm_q;
        color_d  = color_q;
        for (int b = 0; b < 4; b++) begin
            if (wr_src && BYTEEN[b]) src_d[8*b +: 8] = WDATA[8*b +: 8];
            if (wr_frm && BYTEEN[b]) frm_d[8*b +: 8] = WDATA[8*b +: 8];
        end
        src_d[1:0] = 2'b00;
        frm_d[1:0] = 2'b00;
        if (wr_color && BYTEEN[0]) color_d = WDATA[2:0];
        if (wr_int && BYTEEN[0]) begin
            irq_en_d = WDATA[0];
            if (WDATA[1]) begin
                done_d = 1'b0;
                tmo_d  = 1'b0;
            end
        end
        if (finish) done_d = 1'b1;
        if (timeout_hit) tmo_d = 1'b1;
    end

    // Read-data decode from current register contents.
    always_comb begin
        rd_val = '0;
        case (RDADDR)
            ADDR_STAT:  rd_val = {30'b0, tmo_q, state_q == StRun};
            ADDR_INT:   rd_val = {30'b0, done_q, irq_en_q};
            ADDR_SRC:   rd_val = src_q;
            ADDR_FRM:   rd_val = frm_q;
            ADDR_COLOR: rd_val = {29'b0, color_q};
            default:    rd_val = '0;
        endcase
    end

    // State, registers and registered outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q    <= StIdle;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            src_q      <= '0;
            frm_q      <= '0;
            color_q    <= '0;
            RDATA      <= '0;
            FLT_IRQ    <= 1'b0;
            core_start <= 1'b0;
            core_src   <= '0;
            core_frm   <= '0;
            core_color <= '0;
        end else begin
            state_q    <= state_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            src_q      <= src_d;
            frm_q      <= frm_d;
            color_q    <= color_d;
            FLT_IRQ    <= irq_en_q & done_q;
            core_start <= start;
            if (RDEN) RDATA <= rd_val;
            // Core-facing copies only move on a launch.
            if (start) begin
                core_src   <= src_q;
                core_frm   <= frm_q;
                core_color <= color_q;
            end
        end
    end

endmodule

// File: doc/flt_regctrl.md
# flt_regctrl

Register-bus responder and run controller for the filter block. It decodes the 16-bit register bus (write port WRADDR/BYTEEN/WREN/WDATA, read port RDADDR/RDEN/RDATA) at FLTCTRL..FLTCOLOR. It holds the VRAM source/frame base addresses and colour mask, and launches the filter core with a start pulse. It also tracks busy/done and raises FLT_IRQ. It sits between the register bus and the filter datapath, whose AXI master uses this block's latched addresses.

## Interface
- BASE_ADDR, 16'h4000, register window base; offsets 0x00/04/08/0c/10/14.
- TIMEOUT_CYCLES, 24'hFF_FFFF, watchdog limit in RUN (only with FLT_TIMEOUT_EN).
- Clocking: one clock; reset is synchronous and active-low.
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  synchronous active-low reset.
- WRADDR  in  16  write address.
- BYTEEN  in  4  write byte enables.
- WREN  in  1  write strobe, one cycle per write.
- WDATA  in  32  write data.
- RDADDR  in  16  read address.
- RDEN  in  1  read strobe.
- RDATA  out  32  registered read data.
- FLT_IRQ  out  1  interrupt, level, registered.
- core_start  out  1  one-cycle start pulse to filter core.
- core_src  out  32  active source base, latched at start.
- core_frm  out  32  active frame base, latched at start.
- core_color  out  3  active colour mask {R,G,B}, latched at start.
- core_done  in  1  one-cycle completion pulse from core.

## Operation
- FLTCTRL (+0x00): writing bit0=1 with BYTEEN[0] in IDLE starts a run. It is ignored in RUN. Reads 0.
- FLTSTAT (+0x04), RO: bit0 busy (1 in RUN); bit1 timeout sticky (with macro). Other bits 0.
- FLTINT (+0x08): bit0 IRQ enable (RW). bit1 done flag: reads the flag; writing 1 clears it (W1C); writing 1 also clears the timeout sticky.
- FLTVRAM_SRC (+0x0c) / FLTVRAM_FRM (+0x10): RW, byte-enabled. Bits[1:0] are hardwired 0.
- FLTCOLOR (+0x14): bits[2:0] RW, byte-enabled. Upper bits read 0.
- Unmapped addresses: writes are ignored; reads return 0.
- FSM IDLE -> RUN on a valid start write. On that transition:
  - core_start=1 for exactly one cycle.
  - core_src/core_frm/core_color load from the programming registers in the same cycle.
- Register writes during RUN update the programming registers only; the core_* outputs stay unchanged until the next start.
- RUN -> IDLE on core_done; done flag set. core_done in IDLE is ignored.
- FLT_IRQ = enable & flag, registered.
- Same-cycle flag set (core_done) and W1C clear: set wins.

## Timing
- Reset values:
  - RDATA, core_* outputs, FLT_IRQ: 0.
  - All registers 0; FSM IDLE.
- Write takes effect at the rising edge where WREN=1. Register readback reflects it from the next edge.
- Read latency is 1 cycle: RDEN sampled high at edge k gives RDATA valid after edge k and held until the next RDEN.
- Start write at edge k: busy=1 and core_start=1 after edge k; core_start drops after k+1.
- core_done at edge k: busy=0 and flag=1 after edge k; FLT_IRQ rises after k+1.
- Start write in the same cycle as core_done while in RUN: done is processed and the start is ignored (RUN when sampled).
- Reset mid-RUN: returns to IDLE with all registers cleared; no core_start is emitted.

## Configuration
- FLT_TIMEOUT_EN defined:
  - A 24-bit counter clears at start and counts every RUN cycle.
  - When it reaches TIMEOUT_CYCLES: force IDLE, set the done flag and the FLTSTAT bit1 sticky.
- FLT_TIMEOUT_EN undefined: no counter; FLTSTAT bit1 reads 0.

## Test plan
- Reset, read all six registers -> every read returns 32'h0; FLT_IRQ=0.
- Write SRC=32'h2000_0003 (BYTEEN=f), FRM=32'h2012_C000, COLOR=7, then read back -> 32'h2000_0000, 32'h2012_C000, 32'h7.
- Write FLTINT=1, FLTCTRL=1 -> core_start one cycle, core_src=32'h2000_0000, FLTSTAT=1. Then core_done -> FLTSTAT=0, FLT_IRQ=1 two cycles after done. Then write FLTINT=3 -> FLT_IRQ=0, enable stays 1.
- During RUN: write COLOR=1 and FLTCTRL=1 -> no second core_start, core_color stays 7, FLTCOLOR reads 1.
- Drive core_done and W1C write in the same cycle -> flag reads 1 afterwards.
- With FLT_TIMEOUT_EN and TIMEOUT_CYCLES=100: start, withhold core_done -> FLTSTAT=32'h2 after 100 cycles; FLT_IRQ=1 if enabled.
